// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver: two-flop input sync, free-running oversample tick, start-bit
// validation, and a first-word-fall-through RX FIFO with sticky overrun/frame flags.
`timescale 1ns/1ps
module uart_rx_buffered #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int unsigned DivRaw = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned DW     = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned SW     = $clog2(OVERSAMPLE);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;
    state_e        state_q, state_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, fe_event;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok, full, ovr_event;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

    always_comb begin
        tick      = (div_cnt_q == DW'(Div - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    end

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        fe_event = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!sync2_q) begin
                        state_d = StStart;
                        sc_d    = '0;
                    end
                end
                StStart: begin
                    if (sc_q == SW'(OVERSAMPLE / 2 - 1)) begin
                        sc_d    = '0;
                        bit_d   = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d = sync2_q ? StIdle : StData;
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                StData: begin
                    if (sc_q == SW'(OVERSAMPLE - 1)) begin
                        shift_d = {sync2_q, shift_q[7:1]};
                        sc_d    = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StStop;
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                StStop: begin
                    if (sc_q == SW'(OVERSAMPLE - 1)) begin
                        sc_d = '0;
                        if (sync2_q) begin
                            push    = 1'b1;
                            state_d = StIdle;
                        end else begin
                            fe_event = 1'b1;
                            state_d  = StBreak;
                        end
                    end else begin
                        sc_d = sc_q + SW'(1);
                    end
                end
                StBreak: begin
                    if (sync2_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        pop_ok    = rd_en && (count_q != '0);
        // When full, a same-cycle pop frees the slot the push needs.
        push_ok   = push && (!full || pop_ok);
        ovr_event = push && full && !pop_ok;
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop_ok) count_d = count_q + CW'(1);
        if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        overrun_d   = (overrun_q && !clr_err) || ovr_event;
        frame_err_d = (frame_err_q && !clr_err) || fe_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            state_q     <= StIdle;
            sc_q        <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            sc_q        <= sc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: occupancy gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        rx_valid  = (count_q != '0);
        rx_data   = rx_valid ? mem[rd_ptr_q] : 8'h00;
        rx_count  = count_q;
        overrun   = overrun_q;
        frame_err = frame_err_q;
    end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- UART 8N1 receiver with oversampled start-bit validation and a first-word-fall-through RX FIFO.
- Feeds the CPU load path of the memory-mapped IO unit. The CPU pops bytes by reading the UART data address, and reads status and error flags.
- Receive-side counterpart of the IO unit's write-only TX path. Absorbs bursts from the PC while the CPU is busy.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and ≥ 8.
- FIFO_DEPTH, 8, RX FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rd_en  in  1  pop the FIFO head. One cycle per byte.
- clr_err  in  1  clears the sticky overrun and frame_err flags.
- rx_data  out  8  FIFO head byte. Valid only when rx_valid is 1.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky: a received byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (async, active-high):
  - synchronizer flops = 1, FSM = IDLE, all counters = 0, FIFO empty.
  - Outputs: rx_data = 0, rx_valid = 0, rx_count = 0, overrun = 0, frame_err = 0.
  - A reset mid-frame abandons the frame and discards all FIFO contents.
- Input sync: two-flop synchronizer on uart_rx. All FSM decisions use the synced value (2-cycle latency).
- Tick generator:
  - DIV = CLK_HZ / (BAUD*OVERSAMPLE), integer division, minimum 1.
  - Counter 0..DIV-1 emits a 1-cycle tick on wrap.
  - Runs freely; not re-phased on start edges.
- FSM states, evaluated on ticks only:
  - IDLE: synced rx = 0 → START, sample counter sc = 0.
  - START: sc increments per tick. At sc = OVERSAMPLE/2-1:
    - rx = 0 → DATA, sc = 0, bit index = 0.
    - rx = 1 → IDLE (glitch rejected, no flag set).
  - DATA: at sc = OVERSAMPLE-1, sample rx into the shift register (LSB first), sc = 0, bit index + 1. After bit 7 → STOP.
  - STOP: at sc = OVERSAMPLE-1, sample rx:
    - rx = 1 → push the byte, → IDLE.
    - rx = 0 → set frame_err, discard the byte, → BREAK.
  - BREAK: stay until synced rx = 1 on a tick → IDLE. A held-low line therefore produces no further bytes.
- FIFO:
  - Push happens in the cycle of the stop-bit sample tick. rx_valid and rx_data reflect the byte on the next clock edge.
  - First-word-fall-through: rx_data always equals the head entry. Pop advances the head on the rd_en clock edge.
  - rd_en while empty: ignored; pointers and count unchanged.
  - Push while full without a same-cycle pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while count = 1: new byte becomes head, count stays 1.
  - Pointers wrap modulo FIFO_DEPTH. rx_count ranges 0..FIFO_DEPTH.
- Sticky flags:
  - overrun and frame_err hold until clr_err or reset.
  - If clr_err coincides with a new error event, the set wins (flag = 1).

Test Plan (CLK_HZ=1_600_000, BAUD=100_000, OVERSAMPLE=16 → DIV=1, 16 clk per bit; FIFO_DEPTH=4):
- Send 0xA5, 8N1 → within 162 clk of the start edge: rx_valid=1, rx_data=0xA5, rx_count=1, no flags. Pulse rd_en → rx_valid=0, rx_count=0.
- Send 0x01,0x02,0x03,0x04 with no reads → rx_count=4, head=0x01. Send 0x05 → overrun=1, count=4. Pop four times → 0x01..0x04 in order, then rx_valid=0. Pulse clr_err → overrun=0.
- Low glitch of 4 clk on an idle line → FSM returns to IDLE, rx_count=0, no flags. Then send 0x3C → received correctly.
- Send 0x55 with the stop bit driven 0, then hold the line low for 400 clk → frame_err=1, rx_count=0, no extra bytes. Release line, send 0x7E → rx_data=0x7E.
- FIFO full (4 entries), assert rd_en in the exact cycle 0x99 is pushed → overrun=0, count=4, tail entry=0x99.
- Assert rst mid-frame (after bit 3 of 0xF0, with 2 bytes queued) → all outputs 0 immediately. After release, send 0x12 → sole entry 0x12, rx_count=1.
